// File: rtl/fetch_unit_pkg.sv
// Shared MIPS fetch definitions: FSM state encoding and default fetch constants.
package fetch_unit_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFC00_0000;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: pipeline control in, instruction-memory bus, IF/ID outputs to decode.
interface fetch_unit_if;

  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] target;
  logic [4:0]  address;
  logic [31:0] instruction;
  logic [31:0] ir;
  logic [31:0] pc_plus4;
  logic        valid;
  logic        halted;

  modport master (
    input  stall, flush, redirect, target, instruction,
    output address, ir, pc_plus4, valid, halted
  );

  modport slave (
    output stall, flush, redirect, target, instruction,
    input  address, ir, pc_plus4, valid, halted
  );

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: clear drops valid but keeps the payload, load captures a new instruction.
module if_id_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] ir,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir       <= 32'h0;
      pc_plus4 <= 32'h0;
      valid    <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      ir       <= instr_in;
      pc_plus4 <= pc_plus4_in;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, next-PC selection and RUN/HALT control feeding the IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  logic [31:0]  pc_reg;
  logic [31:0]  pc_next;
  logic [31:0]  pc_plus4;
  fetch_state_t state_reg;
  fetch_state_t state_next;
  logic         load_ir;
  logic         clear_ir;
  logic         unused_target_bits;

  // Redirect targets are forced word-aligned, so the low target bits never matter.
  assign unused_target_bits = ^bus.target[1:0];

  assign pc_plus4    = pc_reg + 32'd4;
  assign bus.address = pc_reg[6:2];
  assign bus.halted  = (state_reg == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg    <= RESET_PC;
      state_reg <= RUN;
    end else begin
      pc_reg    <= pc_next;
      state_reg <= state_next;
    end
  end

  always_comb begin
    pc_next    = pc_reg;
    state_next = state_reg;
    load_ir    = 1'b0;
    clear_ir   = 1'b0;
    case (state_reg)
      RUN: begin
        if (bus.redirect) begin
          pc_next  = {bus.target[31:2], 2'b00};
          clear_ir = 1'b1;
        end else if (bus.flush) begin
          clear_ir = 1'b1;
          if (!bus.stall) begin
            pc_next = pc_plus4;
          end
        end else if (bus.stall) begin
          pc_next = pc_reg;
        end else if (bus.instruction == HALT_WORD) begin
          // The halt word is swallowed here: PC stays on it and nothing is issued.
          state_next = HALT;
          clear_ir   = 1'b1;
        end else begin
          load_ir = 1'b1;
          pc_next = pc_plus4;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  if_id_reg u_if_id_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load_ir),
    .clear       (clear_ir),
    .instr_in    (bus.instruction),
    .pc_plus4_in (pc_plus4),
    .ir          (bus.ir),
    .pc_plus4    (bus.pc_plus4),
    .valid       (bus.valid)
  );

endmodule
